// File: rtl/nap_master_txn_governor_if.sv
// -----------------------------------------------------------------------------
// t_AXI4 : AXI4 bundle covering all five channels (AW, W, B, AR, R).
//   ADDR_W / DATA_W / ID_W size the address, data and ID fields.
//   master modport : drives AW/W/AR requests plus BREADY/RREADY.
//   slave  modport : drives AWREADY/WREADY/ARREADY plus the B and R responses.
// -----------------------------------------------------------------------------
interface t_AXI4 #(
  parameter int ADDR_W = 42,
  parameter int DATA_W = 64,
  parameter int ID_W   = 8
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    output rready,
    input  awready, wready, bid, bresp, bvalid, arready,
    input  rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    input  rready,
    output awready, wready, bid, bresp, bvalid, arready,
    output rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/nap_master_txn_governor.sv
// -----------------------------------------------------------------------------
// nap_master_txn_governor : AXI4 governor placed in front of a NAP master port.
// Passes all channels through, caps outstanding read/write bursts, supports
// drain, and records NAP errors, error responses, address-range violations
// and a response-timeout watchdog.
//   i_clk / i_reset       : clock, synchronous active-high reset
//   user (slave)          : user-side AXI4, 42-bit address
//   nap  (master)         : NAP-side AXI4, NAP_ADDR_W-bit address
//   i_nap_error_valid/info: NAP error strobe and code
//   i_drain               : stop accepting new AR/AW (registered, next cycle)
//   i_clear               : clear sticky flags, captured info, error counter
//   o_rd/wr_outstanding   : bursts in flight per direction
//   o_idle                : nothing in flight and no AR/AW request pending
//   o_resp_err_cnt        : saturating count of SLVERR/DECERR responses
//   o_nap_err_sticky/info : first NAP error and its code
//   o_addr_err            : accepted request had non-zero dropped address bits
//   o_timeout             : watchdog expired while traffic was outstanding
// -----------------------------------------------------------------------------
module nap_master_txn_governor #(
  parameter int unsigned MAX_RD_OUTSTANDING = 16,
  parameter int unsigned MAX_WR_OUTSTANDING = 16,
  parameter int unsigned NAP_ADDR_W         = 28,
  parameter int unsigned TIMEOUT_CYCLES     = 4096,
  parameter int unsigned ERR_CNT_W          = 16,
  localparam int unsigned RD_W = $clog2(MAX_RD_OUTSTANDING + 1),
  localparam int unsigned WR_W = $clog2(MAX_WR_OUTSTANDING + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  t_AXI4.slave                 user,
  t_AXI4.master                nap,
  input  logic                 i_nap_error_valid,
  input  logic [2:0]           i_nap_error_info,
  input  logic                 i_drain,
  input  logic                 i_clear,
  output logic [RD_W-1:0]      o_rd_outstanding,
  output logic [WR_W-1:0]      o_wr_outstanding,
  output logic                 o_idle,
  output logic [ERR_CNT_W-1:0] o_resp_err_cnt,
  output logic                 o_nap_err_sticky,
  output logic [2:0]           o_nap_err_info,
  output logic                 o_addr_err,
  output logic                 o_timeout
);

  logic [RD_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [WR_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic                 drain_q;
  logic [31:0]          timer_q, timer_d;
  logic                 timeout_q, timeout_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 nap_err_q, nap_err_d;
  logic [2:0]           nap_info_q, nap_info_d;
  logic                 addr_err_q, addr_err_d;

  logic                 rd_allow_s, wr_allow_s;
  logic                 ar_hs_s, aw_hs_s, r_last_hs_s, r_hs_s, b_hs_s;
  logic [1:0]           err_inc_s;
  logic [ERR_CNT_W:0]   err_sum_s;
  logic                 addr_bad_s;

  // Allow depends only on registered state, so there is no path from a
  // ready input back to a valid output.
  assign rd_allow_s = !drain_q && (rd_cnt_q < RD_W'(MAX_RD_OUTSTANDING));
  assign wr_allow_s = !drain_q && (wr_cnt_q < WR_W'(MAX_WR_OUTSTANDING));

  // AR channel: gated valid/ready, upper address bits dropped
  assign nap.arid     = user.arid;
  assign nap.araddr   = user.araddr[NAP_ADDR_W-1:0];
  assign nap.arlen    = user.arlen;
  assign nap.arsize   = user.arsize;
  assign nap.arburst  = user.arburst;
  assign nap.arvalid  = user.arvalid & rd_allow_s;
  assign user.arready = nap.arready & rd_allow_s;

  // AW channel: same gating using the write counter
  assign nap.awid     = user.awid;
  assign nap.awaddr   = user.awaddr[NAP_ADDR_W-1:0];
  assign nap.awlen    = user.awlen;
  assign nap.awsize   = user.awsize;
  assign nap.awburst  = user.awburst;
  assign nap.awvalid  = user.awvalid & wr_allow_s;
  assign user.awready = nap.awready & wr_allow_s;

  // W, B and R channels: straight pass-through
  assign nap.wdata    = user.wdata;
  assign nap.wstrb    = user.wstrb;
  assign nap.wlast    = user.wlast;
  assign nap.wvalid   = user.wvalid;
  assign user.wready  = nap.wready;

  assign user.bid     = nap.bid;
  assign user.bresp   = nap.bresp;
  assign user.bvalid  = nap.bvalid;
  assign nap.bready   = user.bready;

  assign user.rid     = nap.rid;
  assign user.rdata   = nap.rdata;
  assign user.rresp   = nap.rresp;
  assign user.rlast   = nap.rlast;
  assign user.rvalid  = nap.rvalid;
  assign nap.rready   = user.rready;

  assign ar_hs_s     = user.arvalid & nap.arready & rd_allow_s;
  assign aw_hs_s     = user.awvalid & nap.awready & wr_allow_s;
  assign r_hs_s      = nap.rvalid & user.rready;
  assign r_last_hs_s = r_hs_s & nap.rlast;
  assign b_hs_s      = nap.bvalid & user.bready;

  assign addr_bad_s = (ar_hs_s && (user.araddr[41:NAP_ADDR_W] != '0)) ||
                      (aw_hs_s && (user.awaddr[41:NAP_ADDR_W] != '0));

  assign err_inc_s = {1'b0, r_last_hs_s & nap.rresp[1]} + {1'b0, b_hs_s & nap.bresp[1]};
  assign err_sum_s = {1'b0, err_cnt_q} + (ERR_CNT_W + 1)'(err_inc_s);

  // Next-state logic for counters, watchdog and sticky status
  always_comb begin
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    timer_d    = timer_q;
    timeout_d  = timeout_q;
    err_cnt_d  = err_cnt_q;
    nap_err_d  = nap_err_q;
    nap_info_d = nap_info_q;
    addr_err_d = addr_err_q;

    // Simultaneous increment and decrement cancel; zero never wraps.
    if (ar_hs_s && !r_last_hs_s) begin
      rd_cnt_d = rd_cnt_q + RD_W'(1);
    end else if (!ar_hs_s && r_last_hs_s && (rd_cnt_q != '0)) begin
      rd_cnt_d = rd_cnt_q - RD_W'(1);
    end else begin
      rd_cnt_d = rd_cnt_q;
    end

    if (aw_hs_s && !b_hs_s) begin
      wr_cnt_d = wr_cnt_q + WR_W'(1);
    end else if (!aw_hs_s && b_hs_s && (wr_cnt_q != '0)) begin
      wr_cnt_d = wr_cnt_q - WR_W'(1);
    end else begin
      wr_cnt_d = wr_cnt_q;
    end

    // Watchdog counts idle-response cycles while anything is in flight and
    // parks at the threshold so it cannot wrap back to zero.
    if (i_clear || r_hs_s || b_hs_s || ((rd_cnt_q == '0) && (wr_cnt_q == '0))) begin
      timer_d = 32'd0;
    end else if (timer_q != 32'(TIMEOUT_CYCLES)) begin
      timer_d = timer_q + 32'd1;
    end else begin
      timer_d = timer_q;
    end

    // A clear drops all status first; a same-cycle new event then re-sets it.
    if (i_clear) begin
      timeout_d  = 1'b0;
      err_cnt_d  = '0;
      nap_err_d  = 1'b0;
      nap_info_d = 3'd0;
      addr_err_d = 1'b0;
    end else begin
      timeout_d  = timeout_q;
      err_cnt_d  = err_cnt_q;
      nap_err_d  = nap_err_q;
      nap_info_d = nap_info_q;
      addr_err_d = addr_err_q;
    end

    if ((TIMEOUT_CYCLES != 0) && (timer_d == 32'(TIMEOUT_CYCLES))) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_d;
    end

    if (err_sum_s[ERR_CNT_W]) begin
      err_cnt_d = '1;
    end else if (i_clear) begin
      err_cnt_d = ERR_CNT_W'(err_inc_s);
    end else begin
      err_cnt_d = err_sum_s[ERR_CNT_W-1:0];
    end

    if (i_nap_error_valid && !nap_err_d) begin
      nap_err_d  = 1'b1;
      nap_info_d = i_nap_error_info;
    end else begin
      nap_err_d  = nap_err_d;
    end

    if (addr_bad_s) begin
      addr_err_d = 1'b1;
    end else begin
      addr_err_d = addr_err_d;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      drain_q    <= 1'b0;
      timer_q    <= 32'd0;
      timeout_q  <= 1'b0;
      err_cnt_q  <= '0;
      nap_err_q  <= 1'b0;
      nap_info_q <= 3'd0;
      addr_err_q <= 1'b0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      drain_q    <= i_drain;
      timer_q    <= timer_d;
      timeout_q  <= timeout_d;
      err_cnt_q  <= err_cnt_d;
      nap_err_q  <= nap_err_d;
      nap_info_q <= nap_info_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign o_rd_outstanding = rd_cnt_q;
  assign o_wr_outstanding = wr_cnt_q;
  assign o_idle           = (rd_cnt_q == '0) && (wr_cnt_q == '0) && !user.arvalid && !user.awvalid;
  assign o_resp_err_cnt   = err_cnt_q;
  assign o_nap_err_sticky = nap_err_q;
  assign o_nap_err_info   = nap_info_q;
  assign o_addr_err       = addr_err_q;
  assign o_timeout        = timeout_q;

endmodule

// File: tb/tb_nap_master_txn_governor.sv
module tb_nap_master_txn_governor;

  logic       clk;
  logic       rst;
  logic       nap_err_valid;
  logic [2:0] nap_err_info;
  logic       drain;
  logic       clear;
  logic [2:0] rd_out;
  logic [2:0] wr_out;
  logic       idle;
  logic [1:0] err_cnt;
  logic       err_sticky;
  logic [2:0] err_info;
  logic       addr_err;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  t_AXI4 #(.ADDR_W(42)) user_if ();
  t_AXI4 #(.ADDR_W(28)) nap_if ();

  nap_master_txn_governor #(
    .MAX_RD_OUTSTANDING(4),
    .MAX_WR_OUTSTANDING(4),
    .NAP_ADDR_W(28),
    .TIMEOUT_CYCLES(100),
    .ERR_CNT_W(2)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .user(user_if.slave),
    .nap(nap_if.master),
    .i_nap_error_valid(nap_err_valid),
    .i_nap_error_info(nap_err_info),
    .i_drain(drain),
    .i_clear(clear),
    .o_rd_outstanding(rd_out),
    .o_wr_outstanding(wr_out),
    .o_idle(idle),
    .o_resp_err_cnt(err_cnt),
    .o_nap_err_sticky(err_sticky),
    .o_nap_err_info(err_info),
    .o_addr_err(addr_err),
    .o_timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    user_if.awid = 8'd0; user_if.awaddr = 42'd0; user_if.awlen = 8'd0;
    user_if.awsize = 3'd3; user_if.awburst = 2'd1; user_if.awvalid = 1'b0;
    user_if.wdata = 64'd0; user_if.wstrb = 8'hFF; user_if.wlast = 1'b0; user_if.wvalid = 1'b0;
    user_if.bready = 1'b1;
    user_if.arid = 8'd0; user_if.araddr = 42'd0; user_if.arlen = 8'd0;
    user_if.arsize = 3'd3; user_if.arburst = 2'd1; user_if.arvalid = 1'b0;
    user_if.rready = 1'b1;
    nap_if.awready = 1'b0; nap_if.wready = 1'b0;
    nap_if.bid = 8'd0; nap_if.bresp = 2'b00; nap_if.bvalid = 1'b0;
    nap_if.arready = 1'b0;
    nap_if.rid = 8'd0; nap_if.rdata = 64'd0; nap_if.rresp = 2'b00;
    nap_if.rlast = 1'b0; nap_if.rvalid = 1'b0;
    nap_err_valid = 1'b0; nap_err_info = 3'd0; drain = 1'b0; clear = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (rd_out !== 3'd0) begin $display("FAIL reset_rd got=%0d exp=0", rd_out); bad++; end
    total++; if (wr_out !== 3'd0) begin $display("FAIL reset_wr got=%0d exp=0", wr_out); bad++; end
    total++; if (idle !== 1'b1) begin $display("FAIL reset_idle got=%0b exp=1", idle); bad++; end
    total++; if (err_cnt !== 2'd0) begin $display("FAIL reset_errcnt got=%0d exp=0", err_cnt); bad++; end
    total++; if ({err_sticky, err_info, addr_err, timeout} !== 6'd0) begin
      $display("FAIL reset_flags got=%b exp=000000", {err_sticky, err_info, addr_err, timeout}); bad++;
    end
  endtask

  task automatic test_rd_cap();
    do_reset();
    nap_if.arready = 1'b1;
    user_if.arvalid = 1'b1;
    user_if.araddr = 42'h000_0123_4560;
    #1;
    total++; if (nap_if.araddr !== 28'h123_4560) begin $display("FAIL araddr_pass got=%h exp=1234560", nap_if.araddr); bad++; end
    for (int i = 0; i < 4; i++) begin
      total++; if (nap_if.arvalid !== 1'b1) begin $display("FAIL cap_arvalid%0d got=%0b exp=1", i, nap_if.arvalid); bad++; end
      tick();
    end
    tick();
    tick();
    #1;
    total++; if (rd_out !== 3'd4) begin $display("FAIL cap_rd got=%0d exp=4", rd_out); bad++; end
    total++; if (nap_if.arvalid !== 1'b0) begin $display("FAIL cap_hold_arvalid got=%0b exp=0", nap_if.arvalid); bad++; end
    total++; if (user_if.arready !== 1'b0) begin $display("FAIL cap_hold_arready got=%0b exp=0", user_if.arready); bad++; end
    nap_if.rvalid = 1'b1; nap_if.rlast = 1'b1; nap_if.rdata = 64'h0000_0000_DEAD_BEEF;
    #1;
    total++; if (user_if.rdata !== 64'h0000_0000_DEAD_BEEF) begin $display("FAIL rdata_pass got=%h exp=deadbeef", user_if.rdata); bad++; end
    total++; if (nap_if.arvalid !== 1'b0) begin $display("FAIL cap_same_cycle_hold got=%0b exp=0", nap_if.arvalid); bad++; end
    tick();
    nap_if.rvalid = 1'b0; nap_if.rlast = 1'b0;
    #1;
    total++; if (rd_out !== 3'd3) begin $display("FAIL cap_after_r got=%0d exp=3", rd_out); bad++; end
    total++; if (nap_if.arvalid !== 1'b1) begin $display("FAIL cap_fifth_ar got=%0b exp=1", nap_if.arvalid); bad++; end
    tick();
    user_if.arvalid = 1'b0;
    #1;
    total++; if (rd_out !== 3'd4) begin $display("FAIL cap_fifth_rd got=%0d exp=4", rd_out); bad++; end
  endtask

  task automatic test_simultaneous();
    do_reset();
    nap_if.arready = 1'b1;
    user_if.arvalid = 1'b1;
    tick(); tick(); tick();
    #1;
    total++; if (rd_out !== 3'd3) begin $display("FAIL sim_pre got=%0d exp=3", rd_out); bad++; end
    nap_if.rvalid = 1'b1; nap_if.rlast = 1'b1;
    #1;
    total++; if (nap_if.arvalid !== 1'b1) begin $display("FAIL sim_nostall got=%0b exp=1", nap_if.arvalid); bad++; end
    tick();
    user_if.arvalid = 1'b0; nap_if.rvalid = 1'b0; nap_if.rlast = 1'b0;
    #1;
    total++; if (rd_out !== 3'd3) begin $display("FAIL sim_rd got=%0d exp=3", rd_out); bad++; end
  endtask

  task automatic test_drain_wr();
    do_reset();
    nap_if.awready = 1'b1;
    user_if.awvalid = 1'b1;
    tick(); tick();
    user_if.awvalid = 1'b0;
    drain = 1'b1;
    #1;
    total++; if (wr_out !== 3'd2) begin $display("FAIL drain_pre got=%0d exp=2", wr_out); bad++; end
    total++; if (idle !== 1'b0) begin $display("FAIL drain_busy got=%0b exp=0", idle); bad++; end
    tick();
    user_if.awvalid = 1'b1;
    #1;
    total++; if (nap_if.awvalid !== 1'b0) begin $display("FAIL drain_awvalid got=%0b exp=0", nap_if.awvalid); bad++; end
    total++; if (user_if.awready !== 1'b0) begin $display("FAIL drain_awready got=%0b exp=0", user_if.awready); bad++; end
    tick();
    user_if.awvalid = 1'b0;
    nap_if.bvalid = 1'b1;
    tick(); tick();
    nap_if.bvalid = 1'b0;
    #1;
    total++; if (wr_out !== 3'd0) begin $display("FAIL drain_wr got=%0d exp=0", wr_out); bad++; end
    total++; if (idle !== 1'b1) begin $display("FAIL drain_idle got=%0b exp=1", idle); bad++; end
    drain = 1'b0;
  endtask

  task automatic test_resp_err();
    do_reset();
    nap_if.arready = 1'b1; nap_if.awready = 1'b1;
    user_if.arvalid = 1'b1; user_if.awvalid = 1'b1;
    tick();
    user_if.arvalid = 1'b0; user_if.awvalid = 1'b0;
    nap_if.bvalid = 1'b1; nap_if.bresp = 2'b10;
    nap_if.rvalid = 1'b1; nap_if.rlast = 1'b1; nap_if.rresp = 2'b11;
    tick();
    nap_if.rvalid = 1'b0; nap_if.rlast = 1'b0;
    nap_if.bvalid = 1'b0;
    #1;
    total++; if (err_cnt !== 2'd2) begin $display("FAIL resp_err_two got=%0d exp=2", err_cnt); bad++; end
    total++; if ({rd_out, wr_out} !== 6'd0) begin $display("FAIL resp_err_cnts got=%0d/%0d exp=0/0", rd_out, wr_out); bad++; end
    nap_if.bvalid = 1'b1;
    tick();
    #1;
    total++; if (err_cnt !== 2'd3) begin $display("FAIL resp_err_three got=%0d exp=3", err_cnt); bad++; end
    nap_if.rvalid = 1'b1; nap_if.rlast = 1'b1;
    tick();
    nap_if.bvalid = 1'b0; nap_if.rvalid = 1'b0; nap_if.rlast = 1'b0;
    nap_if.bresp = 2'b00; nap_if.rresp = 2'b00;
    #1;
    total++; if (err_cnt !== 2'd3) begin $display("FAIL resp_err_sat got=%0d exp=3", err_cnt); bad++; end
  endtask

  task automatic test_nap_err();
    nap_err_valid = 1'b1; nap_err_info = 3'd5;
    tick();
    nap_err_info = 3'd2;
    tick();
    nap_err_valid = 1'b0;
    #1;
    total++; if (err_sticky !== 1'b1) begin $display("FAIL naperr_flag got=%0b exp=1", err_sticky); bad++; end
    total++; if (err_info !== 3'd5) begin $display("FAIL naperr_info got=%0d exp=5", err_info); bad++; end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    total++; if ({err_sticky, err_info} !== 4'd0) begin $display("FAIL naperr_clear got=%b exp=0000", {err_sticky, err_info}); bad++; end
    total++; if (err_cnt !== 2'd0) begin $display("FAIL clear_errcnt got=%0d exp=0", err_cnt); bad++; end
    clear = 1'b1; nap_err_valid = 1'b1; nap_err_info = 3'd6;
    tick();
    clear = 1'b0; nap_err_valid = 1'b0;
    #1;
    total++; if ({err_sticky, err_info} !== 4'b1110) begin $display("FAIL naperr_clear_race got=%b exp=1110", {err_sticky, err_info}); bad++; end
  endtask

  task automatic test_timeout_addr();
    int k;
    do_reset();
    nap_if.arready = 1'b1;
    user_if.arvalid = 1'b1;
    tick();
    user_if.arvalid = 1'b0;
    k = 0;
    while (timeout !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    total++; if (k !== 100) begin $display("FAIL timeout_delay got=%0d exp=100", k); bad++; end
    total++; if (addr_err !== 1'b0) begin $display("FAIL addr_err_pre got=%0b exp=0", addr_err); bad++; end
    nap_if.awready = 1'b1;
    user_if.awvalid = 1'b1;
    user_if.awaddr = 42'h1_0000_0000;
    #1;
    total++; if (nap_if.awaddr !== 28'd0) begin $display("FAIL awaddr_trunc got=%h exp=0", nap_if.awaddr); bad++; end
    tick();
    user_if.awvalid = 1'b0;
    #1;
    total++; if (addr_err !== 1'b1) begin $display("FAIL addr_err got=%0b exp=1", addr_err); bad++; end
    total++; if (timeout !== 1'b1) begin $display("FAIL timeout_sticky got=%0b exp=1", timeout); bad++; end
  endtask

  initial begin
    test_reset();
    test_rd_cap();
    test_simultaneous();
    test_drain_wr();
    test_resp_err();
    test_nap_err();
    test_timeout_addr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
